// File: rtl/alu_share_pkg.sv
// Shared types and helpers for the round-robin ALU sharing block.
package alu_share_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int unsigned MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First valid index scanning ptr, ptr+1, ... modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         ptr,
                                    input int unsigned        n);
    pick_t      p;
    logic [2:0] j;
    p = '0;
    for (int unsigned k = 0; k < n; k++) begin
      j = 3'((32'(ptr) + k) % n);
      if (!p.found && valid[j]) begin
        p.found = 1'b1;
        p.idx   = j;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/alu_share_dp.sv
// Combinational ALU datapath: truncated unsigned add, carry-in forwarded as carry-out.
module alu_share_dp #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout
);

  assign o_result = i_a + i_b;
  assign o_cout   = i_cin;

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU datapath among NREQ requesters,
// with a single-entry registered response stage tagged by requester id.
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter  int unsigned NREQ  = 3,
  parameter  int unsigned WIDTH = 3,
  localparam int unsigned IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_cout
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  pick_t            w_pick;
  logic             w_free;
  logic             w_grant;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [WIDTH-1:0] w_result;
  logic             w_cout;

  assign w_free  = (r_state == EMPTY) | rsp_ready;
  assign w_pick  = rr_pick(8'(req_valid), 3'(r_ptr), NREQ);
  assign w_grant = |(req_valid & req_ready);

  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_pick.idx == 3'(i)) begin
        w_a   = req_a[i*WIDTH +: WIDTH];
        w_b   = req_b[i*WIDTH +: WIDTH];
        w_cin = req_cin[i];
      end
    end
  end

  alu_share_dp #(.WIDTH(WIDTH)) u_dp (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_cin    (w_cin),
    .o_result (w_result),
    .o_cout   (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: if (w_grant) w_state_nxt = FULL;
      FULL:  if (w_grant) w_state_nxt = FULL;
             else if (rsp_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // req_ready is forced low during reset even though the stage reads as EMPTY.
  always_comb begin
    rsp_valid = (r_state == FULL);
    req_ready = '0;
    if (rst_n && w_free && w_pick.found) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (w_pick.idx == 3'(i)) req_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_grant) begin
      r_ptr    <= (w_pick.idx == 3'(NREQ-1)) ? '0 : IDW'(w_pick.idx + 3'd1);
      r_id     <= IDW'(w_pick.idx);
      r_result <= w_result;
      r_cout   <= w_cout;
    end
  end

  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_cout   = r_cout;

endmodule
